// File: rtl/regfile_write_sched.sv
// Round-robin arbiter for the register file's single write port.
// Holds En and data for WR_CYCLES clocks, then acks the winner.
module regfile_write_sched #(
  parameter int NUM_REQ   = 2,
  parameter int NUM_REGS  = 8,
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 8,
  parameter int WR_CYCLES = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REGS-1:0]       wr_en,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy,
  output logic                      err
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              drop_q;
  logic [CNT_W-1:0]  cnt;

  logic              any_req;
  logic              found;
  logic [ID_W-1:0]   win;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;
  logic              drop_sel;
  logic              last;
  logic [ID_W-1:0]   ptr_nx;

  assign any_req = |req;
  assign last    = (state == WRITE) &&
                   (cnt == CNT_W'(WR_CYCLES - 1));

  // Search starts at rr_ptr and wraps, so the last winner goes to the back.
  always_comb begin
    win   = rr_ptr;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found &&
          req[ID_W'((int'(rr_ptr) + j) % NUM_REQ)]) begin
        win   = ID_W'((int'(rr_ptr) + j) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (int'(win) == j) begin
        addr_sel = req_addr[j*ADDR_W +: ADDR_W];
        data_sel = req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    drop_sel = 1'b0;
    if (int'(addr_sel) >= NUM_REGS) begin
      drop_sel = 1'b1;
    end
    if ((ZERO_REG != 0) && (addr_sel == '0)) begin
      drop_sel = 1'b1;
    end
  end

  always_comb begin
    ptr_nx = id_q + ID_W'(1);
    if (int'(id_q) == NUM_REQ - 1) begin
      ptr_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = WRITE;
      WRITE:   if (last)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant-time capture; later input changes cannot disturb the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      id_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      drop_q <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        id_q   <= win;
        addr_q <= addr_sel;
        data_q <= data_sel;
        drop_q <= drop_sel;
        cnt    <= '0;
      end
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        rr_ptr <= ptr_nx;
      end
    end
  end

  always_comb begin
    ack     = '0;
    wr_en   = '0;
    wr_data = '0;
    busy    = 1'b0;
    err     = 1'b0;
    if (state == WRITE) begin
      busy    = 1'b1;
      wr_data = data_q;
      err     = last && drop_q;
      for (int r = 0; r < NUM_REGS; r++) begin
        wr_en[r] = !drop_q && (int'(addr_q) == r);
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        ack[j] = last && (int'(id_q) == j);
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Bench for regfile_write_sched: two instances (WR_CYCLES 2 and 1)
// against a queue-based model of the write schedule.
module tb_regfile_write_sched;

  localparam int NR   = 2;
  localparam int NREG = 8;
  localparam int AW   = 4;
  localparam int DW   = 8;

  typedef struct packed {
    logic [NR-1:0]   ack;
    logic [NREG-1:0] en;
    logic [DW-1:0]   d;
    logic            busy;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  logic [NR-1:0]    req[2];
  logic [NR*AW-1:0] req_addr[2];
  logic [NR*DW-1:0] req_data[2];
  logic [NR-1:0]    ack[2];
  logic [NREG-1:0]  wr_en[2];
  logic [DW-1:0]    wr_data[2];
  logic             busy[2];
  logic             err[2];

  int n_chk = 0;
  int n_fail = 0;

  exp_t        q[2][$];
  int          ptr[2];
  bit          idle_m[2];
  logic [DW-1:0] mreg[2][NREG];
  logic [DW-1:0] phys[2][NREG];

  bit            pend[2][NR];
  logic [AW-1:0] pa[2][NR];
  logic [DW-1:0] pd[2][NR];

  always #5 clk = ~clk;

  regfile_write_sched #(
    .NUM_REQ(NR), .NUM_REGS(NREG), .ADDR_W(AW),
    .DATA_W(DW), .WR_CYCLES(2), .ZERO_REG(1)
  ) u_w2 (
    .clk(clk), .rst(rst),
    .req(req[0]), .req_addr(req_addr[0]), .req_data(req_data[0]),
    .ack(ack[0]), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
    .busy(busy[0]), .err(err[0])
  );

  regfile_write_sched #(
    .NUM_REQ(NR), .NUM_REGS(NREG), .ADDR_W(AW),
    .DATA_W(DW), .WR_CYCLES(1), .ZERO_REG(1)
  ) u_w1 (
    .clk(clk), .rst(rst),
    .req(req[1]), .req_addr(req_addr[1]), .req_data(req_data[1]),
    .ack(ack[1]), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
    .busy(busy[1]), .err(err[1])
  );

  // Stand-in for the flip-flop register file fed by the strobes.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NREG; r++) begin
        if (clr) phys[k][r] <= '0;
        else if (wr_en[k][r]) phys[k][r] <= wr_data[k];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wcyc(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // One grant: pick the winner, queue its whole WRITE window.
  task automatic grant(input int k);
    int w;
    int n;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit drop;
    exp_t e;
    w = -1;
    for (int j = 0; j < NR; j++) begin
      int c;
      c = (ptr[k] + j) % NR;
      if (w < 0 && req[k][c]) w = c;
    end
    a = req_addr[k][w*AW +: AW];
    d = req_data[k][w*DW +: DW];
    drop = (int'(a) >= NREG) || (a == '0);
    n = wcyc(k);
    for (int c = 1; c <= n; c++) begin
      e = '0;
      e.busy = 1'b1;
      e.d = d;
      e.en = drop ? '0 : NREG'(1) << a;
      if (c == n) begin
        e.ack = NR'(1) << w;
        e.err = drop;
      end
      q[k].push_back(e);
    end
    ptr[k] = (w + 1) % NR;
    if (!drop) mreg[k][a] = d;
  endtask

  task automatic step();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        q[k].delete();
        ptr[k] = 0;
      end else if (idle_m[k] && req[k] != '0) begin
        grant(k);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (q[k].size() > 0) begin
        e = q[k].pop_front();
        idle_m[k] = 1'b0;
      end else begin
        e = '0;
        idle_m[k] = 1'b1;
      end
      chk($sformatf("ack%0d", k), 32'(ack[k]), 32'(e.ack));
      chk($sformatf("wr_en%0d", k), 32'(wr_en[k]), 32'(e.en));
      chk($sformatf("wr_data%0d", k), 32'(wr_data[k]), 32'(e.d));
      chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(e.busy));
      chk($sformatf("err%0d", k), 32'(err[k]), 32'(e.err));
    end
  endtask

  task automatic set_in(input int k, input int i, input bit r,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k][i] = r;
    req_addr[k][i*AW +: AW] = a;
    req_data[k][i*DW +: DW] = d;
  endtask

  task automatic run_one(input int k, input int i,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output bit seen, output logic [NREG-1:0] en_or,
                         output bit err_ack, output int lat);
    set_in(k, i, 1'b1, a, d);
    seen = 1'b0;
    en_or = '0;
    err_ack = 1'b0;
    lat = 0;
    while (!seen && lat < 10) begin
      step();
      lat++;
      en_or |= wr_en[k];
      if (ack[k][i]) begin
        seen = 1'b1;
        err_ack = err[k];
      end
    end
    req[k][i] = 1'b0;
  endtask

  initial begin
    bit seen;
    bit err_ack;
    int lat;
    int n_ack;
    int n_busy;
    logic [NR-1:0] prev;
    logic [NREG-1:0] en_or;

    for (int k = 0; k < 2; k++) begin
      idle_m[k] = 1'b1;
      ptr[k] = 0;
      for (int r = 0; r < NREG; r++) mreg[k][r] = '0;
      for (int i = 0; i < NR; i++) pend[k][i] = 1'b0;
      req[k] = '1;
      req_addr[k] = '0;
      req_data[k] = '0;
    end

    // T1: reset with both requests high
    clr = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("t1_busy", 32'(busy[0]), 32'd0);
      chk("t1_en", 32'(wr_en[0]), 32'd0);
    end
    clr = 1'b0;
    rst = 1'b0;
    req[0] = '0;
    req[1] = '0;

    // T2: single write to reg 5
    set_in(0, 0, 1'b1, 4'd5, 8'hA5);
    step();
    chk("t2_en1", 32'(wr_en[0]), 32'h20);
    chk("t2_ack1", 32'(ack[0]), 32'd0);
    step();
    chk("t2_en2", 32'(wr_en[0]), 32'h20);
    chk("t2_ack2", 32'(ack[0]), 32'h1);
    req[0] = '0;
    step();
    chk("t2_busy", 32'(busy[0]), 32'd0);
    chk("t2_reg5", 32'(phys[0][5]), 32'hA5);

    // T3: continuous contention straight out of reset
    rst = 1'b1;
    set_in(0, 0, 1'b1, 4'd1, 8'h11);
    set_in(0, 1, 1'b1, 4'd2, 8'h22);
    step();
    rst = 1'b0;
    n_ack = 0;
    n_busy = 0;
    prev = 2'b10;
    for (int c = 0; c < 12; c++) begin
      step();
      if (busy[0]) n_busy++;
      if (ack[0] != '0) begin
        n_ack++;
        chk("t3_alt", 32'(ack[0]), 32'((prev == 2'b01) ? 2'b10 : 2'b01));
        prev = ack[0];
      end
    end
    chk("t3_nack", 32'(n_ack), 32'd4);
    chk("t3_nbusy", 32'(n_busy), 32'd8);
    req[0] = '0;
    step();

    // T4: dropped writes to reg 0 and reg 9
    run_one(0, 0, 4'd0, 8'h77, seen, en_or, err_ack, lat);
    chk("t4a_seen", 32'(seen), 32'd1);
    chk("t4a_en", 32'(en_or), 32'd0);
    chk("t4a_err", 32'(err_ack), 32'd1);
    run_one(0, 0, 4'd9, 8'h99, seen, en_or, err_ack, lat);
    chk("t4b_seen", 32'(seen), 32'd1);
    chk("t4b_en", 32'(en_or), 32'd0);
    chk("t4b_err", 32'(err_ack), 32'd1);
    step();
    chk("t4_reg0", 32'(phys[0][0]), 32'd0);

    // T5: reset in the first WRITE cycle, then re-issue
    set_in(0, 0, 1'b1, 4'd3, 8'h3C);
    step();
    chk("t5_en", 32'(wr_en[0]), 32'h08);
    rst = 1'b1;
    step();
    chk("t5_rst_en", 32'(wr_en[0]), 32'd0);
    chk("t5_rst_ack", 32'(ack[0]), 32'd0);
    chk("t5_rst_busy", 32'(busy[0]), 32'd0);
    rst = 1'b0;
    run_one(0, 0, 4'd3, 8'h3C, seen, en_or, err_ack, lat);
    chk("t5_seen", 32'(seen), 32'd1);
    chk("t5_lat", 32'(lat), 32'd2);
    step();
    chk("t5_reg3", 32'(phys[0][3]), 32'h3C);

    // T6: single-cycle writes, request withdrawn right after grant
    set_in(1, 0, 1'b1, 4'd6, 8'h5A);
    step();
    req[1] = '0;
    chk("t6_en", 32'(wr_en[1]), 32'h40);
    chk("t6_ack", 32'(ack[1]), 32'h1);
    chk("t6_data", 32'(wr_data[1]), 32'h5A);
    step();
    chk("t6_busy", 32'(busy[1]), 32'd0);
    chk("t6_reg6", 32'(phys[1][6]), 32'h5A);
    set_in(1, 0, 1'b1, 4'd1, 8'hC1);
    set_in(1, 1, 1'b1, 4'd2, 8'hC2);
    step();
    chk("t6_rr", 32'(ack[1]), 32'h2);
    req[1] = '0;
    step();

    // Random traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < NR; i++) begin
          if (ack[k][i]) begin
            pend[k][i] = 1'b0;
          end else if (pend[k][i] && $urandom_range(0, 31) == 0) begin
            pend[k][i] = 1'b0;
          end else if (!pend[k][i] && $urandom_range(0, 2) == 0) begin
            pend[k][i] = 1'b1;
            pa[k][i] = ($urandom_range(0, 7) == 0) ?
                       AW'($urandom_range(8, 15)) :
                       AW'($urandom_range(0, 7));
            pd[k][i] = DW'($urandom);
          end else if (pend[k][i] && $urandom_range(0, 15) == 0) begin
            pd[k][i] = DW'($urandom);
          end
          set_in(k, i, pend[k][i], pa[k][i], pd[k][i]);
        end
      end
      step();
    end

    req[0] = '0;
    req[1] = '0;
    for (int c = 0; c < 5; c++) step();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NREG; r++) begin
        chk($sformatf("reg%0d_%0d", k, r), 32'(phys[k][r]), 32'(mreg[k][r]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
